// File: rtl/instr_src_pkg.sv
// Shared types for the instruction-source sequencer: FSM states, the NOP encoding and the FIFO entry.
package instr_src_pkg;

    typedef enum logic [1:0] {
        ST_MEM   = 2'd0,
        ST_EXT   = 2'd1,
        ST_DRAIN = 2'd2
    } instr_src_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        last;
        logic [31:0] instr;
    } instr_entry_t;

endpackage

// File: rtl/instr_src_fifo.sv
// Synchronous instruction FIFO; push/pop take effect at the clock edge, the head is visible combinationally.
// A full FIFO refuses pushes even when popping in the same cycle; flush empties it and drops a same-cycle push.
module instr_src_fifo
    import instr_src_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  instr_entry_t push_dat_i,
    input  logic         pop_i,
    output instr_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    instr_entry_t   mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           push_en;
    logic           pop_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/instr_src_ctrl.sv
// Instruction-source sequencer: buffers external words, injects them one per unstalled cycle, drains with NOPs.
// First word appears one edge after it is popped; stall freezes all registered outputs; req_ready = FIFO not full.
// Optional starvation timeout enabled by defining INSTR_SRC_TIMEOUT_EN.
module instr_src_ctrl
    import instr_src_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 5,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_en,
    input  logic        abort,
    input  logic        stall,
    input  logic        req_valid,
    input  logic [31:0] req_instr,
    input  logic        req_last,
    output logic        req_ready,
    output logic        instr_mode,
    output logic [31:0] instr_ext,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_count,
    output logic        timeout_err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    instr_src_state_e state_q;
    logic             instr_mode_q;
    logic [31:0]      instr_ext_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      issued_count_q;
    logic [DW-1:0]    drain_cnt_q;

    instr_entry_t     push_dat;
    instr_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             flush;
    logic             force_drain;
    logic             pop;
    logic             timeout_hit;

    assign push_dat    = '{last: req_last, instr: req_instr};
    assign req_ready   = !fifo_full;
    assign flush       = abort || timeout_hit;
    assign force_drain = flush && (state_q != ST_MEM);
    assign pop         = !flush && !stall && !fifo_empty &&
                         (((state_q == ST_MEM) && ext_en) || (state_q == ST_EXT));

    instr_src_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .push_i     (req_valid),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

`ifdef INSTR_SRC_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] starve_q;
    logic          timeout_err_q;

    assign timeout_hit = (state_q == ST_EXT) && !stall && fifo_empty &&
                         (starve_q == SW'(TIMEOUT - 1));
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (pop || flush || state_q != ST_EXT) starve_q <= '0;
            else if (!stall && fifo_empty)         starve_q <= starve_q + 1'b1;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT is always positive, so this is a constant 0.
    assign timeout_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_MEM;
            instr_mode_q   <= 1'b0;
            instr_ext_q    <= NOP_INSTR;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            issued_count_q <= '0;
            drain_cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (force_drain) begin
                // The NOP driven on this edge already counts as the first drain NOP.
                state_q      <= ST_DRAIN;
                instr_mode_q <= 1'b1;
                instr_ext_q  <= NOP_INSTR;
                busy_q       <= 1'b1;
                drain_cnt_q  <= DW'(1);
            end else begin
                case (state_q)
                    ST_MEM: begin
                        if (pop) begin
                            state_q        <= head.last ? ST_DRAIN : ST_EXT;
                            instr_mode_q   <= 1'b1;
                            instr_ext_q    <= head.instr;
                            busy_q         <= 1'b1;
                            issued_count_q <= 16'd1;
                            drain_cnt_q    <= '0;
                        end
                    end
                    ST_EXT: begin
                        if (!stall) begin
                            if (pop) begin
                                instr_ext_q <= head.instr;
                                if (issued_count_q != 16'hFFFF)
                                    issued_count_q <= issued_count_q + 16'd1;
                                if (head.last) begin
                                    state_q     <= ST_DRAIN;
                                    drain_cnt_q <= '0;
                                end
                            end else begin
                                instr_ext_q <= NOP_INSTR;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!stall) begin
                            instr_ext_q <= NOP_INSTR;
                            if (drain_cnt_q == DW'(DRAIN_CYCLES)) begin
                                state_q      <= ST_MEM;
                                instr_mode_q <= 1'b0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                            end else begin
                                drain_cnt_q <= drain_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_MEM;
                endcase
            end
        end
    end

    assign instr_mode   = instr_mode_q;
    assign instr_ext    = instr_ext_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = issued_count_q;

endmodule

// File: tb/tb_instr_src_ctrl.sv
// Scoreboard bench for instr_src_ctrl: accepted words are queued, the monitor pops them as they issue.
module tb_instr_src_ctrl;
    import instr_src_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_en, abort, stall;
    logic        req_valid, req_last;
    logic [31:0] req_instr;
    logic        req_ready, instr_mode, busy, done, timeout_err;
    logic [31:0] instr_ext;
    logic [15:0] issued_count;

    int checks = 0;
    int errors = 0;
    int nops_since_word = 0;
    int total_nops = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;
    logic        stall_edge;

    always #5 clk = ~clk;

    instr_src_ctrl #(
        .FIFO_DEPTH   (4),
        .DRAIN_CYCLES (5),
        .TIMEOUT      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_en       (ext_en),
        .abort        (abort),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_instr    (req_instr),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .instr_mode   (instr_mode),
        .instr_ext    (instr_ext),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count),
        .timeout_err  (timeout_err)
    );

    always @(posedge clk) stall_edge <= stall;

    // A fresh (unstalled) non-NOP output in external mode must be the next accepted word.
    always @(negedge clk) begin
        if (!reset && instr_mode && !stall_edge) begin
            if (instr_ext == NOP_INSTR) begin
                nops_since_word++;
                total_nops++;
            end else begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h expected none", instr_ext);
                end else begin
                    mon_exp = sb.pop_front();
                    if (instr_ext !== mon_exp) begin
                        errors++;
                        $display("FAIL word_order got %h expected %h", instr_ext, mon_exp);
                    end
                end
                nops_since_word = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w, input logic l);
        int n = 0;
        req_valid = 1'b1; req_instr = w; req_last = l;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout got ready=%b expected 1", req_ready);
        end else begin
            sb.push_back(w);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done got %b expected 1", name, done);
        end
        checks++;
        if (instr_mode !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_mode_at_done got mode=%b busy=%b expected 0 0", name, instr_mode, busy);
        end
        step(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ext_en = 0; abort = 0; stall = 0;
        req_valid = 0; req_last = 0; req_instr = '0;
        step(2);
        checks++; if (instr_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b expected 0", instr_mode); end
        checks++; if (instr_ext !== 32'h0000_0013) begin errors++; $display("FAIL reset_ext got %h expected 00000013", instr_ext); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", issued_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b expected 0", timeout_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", req_ready); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        ext_en = 1'b1; total_nops = 0;
        push_word(32'h0050_0093, 1'b0);
        checks++; if (instr_mode !== 1'b0) begin errors++; $display("FAIL basic_early_mode got %b expected 0", instr_mode); end
        push_word(32'h00a0_0113, 1'b0);
        checks++; if (instr_mode !== 1'b1 || instr_ext !== 32'h0050_0093) begin
            errors++; $display("FAIL basic_first_latency got mode=%b ext=%h expected 1 00500093", instr_mode, instr_ext);
        end
        push_word(32'h0020_81b3, 1'b1);
        wait_done("basic");
        checks++; if (total_nops != 5) begin errors++; $display("FAIL basic_nops got %0d expected 5", total_nops); end
        checks++; if (issued_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d expected 3", issued_count); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_leftover got %0d expected 0", sb.size()); end
    endtask

    task automatic test_full();
        ext_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h1000_0000 + i, i == 3);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b expected 0", req_ready); end
        req_valid = 1'b1; req_instr = 32'hdead_beef; req_last = 1'b1;
        step(3);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || busy !== 1'b0 || instr_mode !== 1'b0) begin
            errors++; $display("FAIL full_hold got ready=%b busy=%b mode=%b expected 0 0 0", req_ready, busy, instr_mode);
        end
        total_nops = 0; ext_en = 1'b1;
        wait_done("full");
        checks++; if (issued_count !== 16'd4) begin errors++; $display("FAIL full_count got %0d expected 4", issued_count); end
        checks++; if (total_nops != 5) begin errors++; $display("FAIL full_nops got %0d expected 5", total_nops); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_leftover got %0d expected 0", sb.size()); end
    endtask

    task automatic test_trickle();
        ext_en = 1'b1; total_nops = 0;
        push_word(32'h2000_0001, 1'b0); step(2);
        push_word(32'h2000_0002, 1'b0); step(2);
        push_word(32'h2000_0003, 1'b1);
        wait_done("trickle");
        checks++; if (total_nops != 9) begin errors++; $display("FAIL trickle_nops got %0d expected 9", total_nops); end
        checks++; if (issued_count !== 16'd3) begin errors++; $display("FAIL trickle_count got %0d expected 3", issued_count); end
    endtask

    task automatic test_stall();
        ext_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h3000_0000 + i, i == 3);
        ext_en = 1'b1; total_nops = 0;
        step(2);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++; if (instr_ext !== 32'h3000_0001 || issued_count !== 16'd2) begin
                errors++; $display("FAIL stall_ext_hold got ext=%h cnt=%0d expected 30000001 2", instr_ext, issued_count);
            end
        end
        stall = 1'b0;
        step(4);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++; if (instr_ext !== NOP_INSTR || instr_mode !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_drain_hold got ext=%h mode=%b busy=%b expected 00000013 1 1", instr_ext, instr_mode, busy);
            end
        end
        stall = 1'b0;
        wait_done("stall");
        checks++; if (total_nops != 5) begin errors++; $display("FAIL stall_nops got %0d expected 5", total_nops); end
        checks++; if (issued_count !== 16'd4) begin errors++; $display("FAIL stall_count got %0d expected 4", issued_count); end
    endtask

    task automatic test_abort();
        ext_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h4000_0000 + i, i == 3);
        ext_en = 1'b1;
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        sb.delete();
        checks++; if (req_ready !== 1'b1 || instr_ext !== NOP_INSTR || instr_mode !== 1'b1) begin
            errors++; $display("FAIL abort_flush got ready=%b ext=%h mode=%b expected 1 00000013 1", req_ready, instr_ext, instr_mode);
        end
        wait_done("abort");
        checks++; if (nops_since_word != 5) begin errors++; $display("FAIL abort_nops got %0d expected 5", nops_since_word); end
        checks++; if (issued_count !== 16'd2) begin errors++; $display("FAIL abort_count got %0d expected 2", issued_count); end
        step(10);
        checks++; if (instr_mode !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle got mode=%b busy=%b expected 0 0", instr_mode, busy);
        end
    endtask

    task automatic test_midreset();
        ext_en = 1'b1;
        push_word(32'h5000_0001, 1'b0);
        push_word(32'h5000_0002, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++; if (instr_mode !== 1'b0 || instr_ext !== NOP_INSTR || busy !== 1'b0 ||
                      issued_count !== 16'd0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_async got mode=%b ext=%h busy=%b cnt=%0d ready=%b expected 0 00000013 0 0 1",
                               instr_mode, instr_ext, busy, issued_count, req_ready);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        step(3);
        checks++; if (instr_mode !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_lost got mode=%b busy=%b expected 0 0", instr_mode, busy);
        end
    endtask

    task automatic test_timeout();
        ext_en = 1'b1; total_nops = 0;
        push_word(32'h6000_0001, 1'b0);
        step(1);
`ifdef INSTR_SRC_TIMEOUT_EN
        step(7);
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early got terr=%b busy=%b expected 0 1", timeout_err, busy);
        end
        step(1);
        checks++; if (timeout_err !== 1'b1 || instr_mode !== 1'b1 || instr_ext !== NOP_INSTR) begin
            errors++; $display("FAIL timeout_hit got terr=%b mode=%b ext=%h expected 1 1 00000013", timeout_err, instr_mode, instr_ext);
        end
        wait_done("timeout");
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b expected 1", timeout_err); end
        checks++; if (total_nops != 12) begin errors++; $display("FAIL timeout_nops got %0d expected 12", total_nops); end
`else
        step(20);
        checks++; if (busy !== 1'b1 || instr_mode !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL notimeout_wait got busy=%b mode=%b terr=%b expected 1 1 0", busy, instr_mode, timeout_err);
        end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done("notimeout");
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_trickle();
        test_stall();
        test_abort();
        test_midreset();
        test_timeout();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
